// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped read-only word cache.
// Holds the address geometry and the controller state encoding.
// Used by cache_store and dm_cache_ctrl.
package cache_pkg;

  localparam int ADDR_W         = 15;
  localparam int DATA_W         = 32;
  localparam int INDEX_W        = 8;
  localparam int TAG_W          = ADDR_W - INDEX_W - 2;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    MEM_READ,
    RESPOND
  } state_t;

endpackage

// File: rtl/cache_store.sv
// Line storage for the direct-mapped cache.
// It holds one data line (4 words), one tag and one valid bit per index.
//   clk, rst  : clock; rst asynchronously invalidates every line
//   rd_index  : line selected for the combinational read
//   rd_valid  : valid bit of the selected line
//   rd_tag    : tag of the selected line
//   rd_line   : the four data words of the selected line
//   wr_en     : writes a whole line, sets its tag and marks it valid
//   wr_index  : line to write
//   wr_tag    : tag to store with the line
//   wr_line   : the four words to store
module cache_store
  import cache_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [INDEX_W-1:0]                        rd_index,
  output logic                                      rd_valid,
  output logic [TAG_W-1:0]                          rd_tag,
  output logic [WORDS_PER_LINE-1:0][DATA_W-1:0]     rd_line,
  input  logic                                      wr_en,
  input  logic [INDEX_W-1:0]                        wr_index,
  input  logic [TAG_W-1:0]                          wr_tag,
  input  logic [WORDS_PER_LINE-1:0][DATA_W-1:0]     wr_line
);

  localparam int LINES = 1 << INDEX_W;

  logic [WORDS_PER_LINE-1:0][DATA_W-1:0] data_mem [LINES];
  logic [TAG_W-1:0]                      tag_mem  [LINES];
  logic [LINES-1:0]                      valid;

  // Data and tags carry no reset: a cleared valid bit is enough to hide them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_index] <= wr_line;
      tag_mem[wr_index]  <= wr_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_index] <= 1'b1;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, read-only word cache controller between the CPU load path
// and main memory. A miss fetches a whole 4-word line with one block read.
//   clk, rst                : clock; asynchronous active-high reset
//   cpu_req, cpu_adr        : read request and word address (taken in IDLE)
//   cpu_ready               : one-cycle pulse, cpu_data is valid
//   cpu_data                : returned word, held until the next cpu_ready
//   cpu_hit                 : 1 = served from the cache, 0 = served by a fill
//   mem_read, mem_adr       : block-read request and line-aligned address
//   mem_done                : main memory has the line on mem_data1..4
//   mem_data1..mem_data4    : line words at offsets 0..3
//   hit_count, miss_count   : saturating hit and miss counters
module dm_cache_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_adr,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_hit,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_adr,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data1,
  input  logic [DATA_W-1:0] mem_data2,
  input  logic [DATA_W-1:0] mem_data3,
  input  logic [DATA_W-1:0] mem_data4,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  state_t              state;
  logic [ADDR_W-1:0]   adr_q;

  logic [1:0]          offset;
  logic [INDEX_W-1:0]  index;
  logic [TAG_W-1:0]    tag;

  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [WORDS_PER_LINE-1:0][DATA_W-1:0] line_data;

  logic                hit;
  logic                fill;

  assign offset = adr_q[1:0];
  assign index  = adr_q[INDEX_W+1:2];
  assign tag    = adr_q[ADDR_W-1:INDEX_W+2];

  assign hit  = line_valid && (line_tag == tag);
  // mem_done is only trusted while we are actually waiting for a line; the
  // stale done that follows the fill edge lands in RESPOND and is dropped.
  assign fill = (state == MEM_READ) && mem_done;

  cache_store u_store (
    .clk      (clk),
    .rst      (rst),
    .rd_index (index),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_line  (line_data),
    .wr_en    (fill),
    .wr_index (index),
    .wr_tag   (tag),
    .wr_line  ({mem_data4, mem_data3, mem_data2, mem_data1})
  );

  // The store is read combinationally by the latched index, so the word
  // returned in RESPOND is the one just written by the fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      adr_q      <= '0;
      cpu_ready  <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_data   <= '0;
      mem_read   <= 1'b0;
      mem_adr    <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            adr_q <= cpu_adr;
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            cpu_ready <= 1'b1;
            cpu_hit   <= 1'b1;
            cpu_data  <= line_data[offset];
            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
            state     <= IDLE;
          end else begin
            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            mem_read <= 1'b1;
            mem_adr  <= {tag, index, 2'b00};
            state    <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (mem_done) begin
            mem_read <= 1'b0;
            state    <= RESPOND;
          end
        end
        RESPOND: begin
          cpu_ready <= 1'b1;
          cpu_hit   <= 1'b0;
          cpu_data  <= line_data[offset];
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl.
// A default instance and a CNT_W=2 instance see the same CPU traffic; a
// behavioural main memory (contents = word address, programmable latency)
// answers block reads. A reference model tracks which lines the cache should
// hold and predicts hit/miss, latency, data and saturating counters.
module tb_dm_cache_ctrl;
  import cache_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_adr;
  logic              cpu_ready, cpu_hit;
  logic [DATA_W-1:0] cpu_data;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_done;
  logic [DATA_W-1:0] mem_data1, mem_data2, mem_data3, mem_data4;
  logic [15:0]       hit_count, miss_count;

  logic              cpu_ready_s, cpu_hit_s, mem_read_s;
  logic [DATA_W-1:0] cpu_data_s;
  logic [ADDR_W-1:0] mem_adr_s;
  logic [1:0]        hit_count_s, miss_count_s;

  int   mem_lat = 0;
  int   wait_cnt = 0;
  logic done_model = 1'b0;
  logic inject_done = 1'b0;

  bit       mvalid [256];
  bit [4:0] mtag   [256];
  int       hits, misses;
  int       total = 0;
  int       bad = 0;

  always #5 clk = ~clk;

  dm_cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_adr(cpu_adr),
    .cpu_ready(cpu_ready), .cpu_data(cpu_data), .cpu_hit(cpu_hit),
    .mem_read(mem_read), .mem_adr(mem_adr), .mem_done(mem_done),
    .mem_data1(mem_data1), .mem_data2(mem_data2),
    .mem_data3(mem_data3), .mem_data4(mem_data4),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  dm_cache_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_adr(cpu_adr),
    .cpu_ready(cpu_ready_s), .cpu_data(cpu_data_s), .cpu_hit(cpu_hit_s),
    .mem_read(mem_read_s), .mem_adr(mem_adr_s), .mem_done(mem_done),
    .mem_data1(mem_data1), .mem_data2(mem_data2),
    .mem_data3(mem_data3), .mem_data4(mem_data4),
    .hit_count(hit_count_s), .miss_count(miss_count_s)
  );

  // Main memory registers the request: done appears mem_lat+1 edges after
  // read is first seen and lingers one cycle after read drops.
  assign mem_done = done_model | inject_done;

  always @(posedge clk) begin
    if (mem_read) begin
      if (wait_cnt >= mem_lat) begin
        done_model <= 1'b1;
        mem_data1  <= 32'(mem_adr);
        mem_data2  <= 32'(mem_adr) + 32'd1;
        mem_data3  <= 32'(mem_adr) + 32'd2;
        mem_data4  <= 32'(mem_adr) + 32'd3;
      end else begin
        done_model <= 1'b0;
        wait_cnt   <= wait_cnt + 1;
      end
    end else begin
      done_model <= 1'b0;
      wait_cnt   <= 0;
    end
  end

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
    hits = 0;
    misses = 0;
  endtask

  // One CPU read. With hold=1 the request stays asserted and the address
  // keeps changing until the response; only the first address may be served.
  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input bit hold, input int lat);
    int       idx;
    int       cyc;
    int       exp_cyc;
    bit       exp_hit;
    bit [4:0] tg;
    idx = int'(a[9:2]);
    tg  = a[14:10];
    exp_hit = mvalid[idx] && (mtag[idx] == tg);
    mem_lat = lat;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_adr = a;
    @(posedge clk);
    #1;
    if (hold) cpu_adr = 15'($urandom);
    else cpu_req = 1'b0;
    if (exp_hit) hits++;
    else begin
      misses++;
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
    exp_cyc = exp_hit ? 1 : 4 + lat;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        checkOutput("mem_read_after_compare", mem_read, exp_hit ? 0 : 1);
        if (!exp_hit) checkOutput("mem_adr", mem_adr, {a[14:2], 2'b00});
      end
      if (cpu_ready) break;
      if (hold) cpu_adr = 15'($urandom);
    end
    if (hold) cpu_req = 1'b0;
    checkOutput("latency", cyc, exp_cyc);
    checkOutput("cpu_data", cpu_data, 32'(a));
    checkOutput("cpu_hit", cpu_hit, exp_hit);
    checkOutput("hit_count", hit_count, sat(hits, 65535));
    checkOutput("miss_count", miss_count, sat(misses, 65535));
    checkOutput("sat_hit_count", hit_count_s, sat(hits, 3));
    checkOutput("sat_miss_count", miss_count_s, sat(misses, 3));
    @(posedge clk);
    #1;
    checkOutput("ready_pulse_end", cpu_ready, 0);
    checkOutput("mem_read_idle", mem_read, 0);
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_adr = '0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    checkOutput("rst_cpu_ready", cpu_ready, 0);
    checkOutput("rst_cpu_hit", cpu_hit, 0);
    checkOutput("rst_cpu_data", cpu_data, 0);
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_mem_adr", mem_adr, 0);
    checkOutput("rst_hit_count", hit_count, 0);
    checkOutput("rst_miss_count", miss_count, 0);

    applyStimulus(15'h0004, 1'b0, 0);
    applyStimulus(15'h0006, 1'b0, 0);
    applyStimulus(15'h0404, 1'b0, 1);
    applyStimulus(15'h0004, 1'b0, 2);
    applyStimulus(15'h0008, 1'b0, 0);
    applyStimulus(15'h000b, 1'b0, 0);

    // Reset while a block read is outstanding.
    mem_lat = 6;
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_adr = 15'h0404;
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_mem_read_active", mem_read, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_mem_read", mem_read, 0);
    checkOutput("mid_rst_miss_count", miss_count, 0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    inject_done = 1'b1;
    @(posedge clk);
    #1;
    inject_done = 1'b0;
    checkOutput("stale_done_mem_read", mem_read, 0);
    checkOutput("stale_done_ready", cpu_ready, 0);
    @(posedge clk);
    #1;
    checkOutput("stale_done_ready2", cpu_ready, 0);
    applyStimulus(15'h0404, 1'b0, 0);
    applyStimulus(15'h0008, 1'b0, 0);

    // Saturation of the narrow counters.
    applyStimulus(15'h0005, 1'b0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(15'h0005, 1'b0, 0);
    checkOutput("sat_hit_final", hit_count_s, 3);

    // Request held high with a wandering address through a miss and a hit.
    applyStimulus(15'h1234, 1'b1, 2);
    applyStimulus(15'h1235, 1'b1, 0);

    for (int n = 0; n < 80; n++) begin
      int t, ix, o;
      t  = $urandom_range(0, 3);
      ix = $urandom_range(0, 7);
      o  = $urandom_range(0, 3);
      applyStimulus(15'((t << 10) | (ix << 2) | o), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
